// File: rtl/bc_fir_sym_mac.sv
// Symmetric odd-length FIR with a strided delay line. One multiplier walks the
// coefficient pairs, and the result is rounded half up and saturated to OUT_W.
module bc_fir_sym_mac #(
    parameter  int DATA_W  = 13,
    parameter  int COEF_W  = 12,
    parameter  int TAPS    = 19,
    parameter  int SPACING = 2,
    parameter  int SHIFT   = 11,
    parameter  int OUT_W   = 13,
    localparam int HALF    = (TAPS - 1) / 2,
    localparam int AW      = $clog2(HALF + 1)
) (
    input  logic                     clock_s,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    output logic                     out_sat,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     coef_err
);

    localparam int LEN    = TAPS * SPACING;
    localparam int NSEL   = 1 << AW;
    localparam int PROD_W = DATA_W + 1 + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    localparam logic [AW-1:0]           HALF_A = AW'(HALF);
    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OMAX   = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN   = ~OMAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

    state_e state_q, state_d;
    logic   accept, coef_ok, mac_en, out_en, wr_ok;

    logic [LEN-1:0][DATA_W-1:0]  line_q;
    logic [NSEL-1:0][COEF_W-1:0] coef_q;
    logic [NSEL-1:0][DATA_W-1:0] tap_lo, tap_hi;
    logic [AW-1:0]               idx_q;
    logic signed [ACC_W-1:0]     acc_q, acc_d, rnd_sum, r_full;
    logic signed [DATA_W:0]      pre;
    logic signed [PROD_W-1:0]    prod;
    logic signed [OUT_W-1:0]     r_sat, out_data_q;
    logic                        clip, out_valid_q, out_sat_q, coef_err_q;

    // tap_lo[k]/tap_hi[k] are the two taps sharing coef[k]; the centre has no partner
    for (genvar k = 0; k < NSEL; k++) begin : g_tap
        if (k < HALF) begin : g_pair
            assign tap_lo[k] = line_q[(k+1)*SPACING-1];
            assign tap_hi[k] = line_q[(TAPS-k)*SPACING-1];
        end else if (k == HALF) begin : g_ctr
            assign tap_lo[k] = line_q[(HALF+1)*SPACING-1];
            assign tap_hi[k] = '0;
        end else begin : g_pad
            assign tap_lo[k] = '0;
            assign tap_hi[k] = '0;
        end
    end

    always_ff @(posedge clock_s or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A new sample may be taken during OUT, so back-to-back samples cost HALF+2 cycles
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (idx_q == HALF_A) state_d = OUT;
            OUT:     state_d = accept ? MAC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q != MAC);
        coef_ok  = (state_q == IDLE);
        mac_en   = (state_q == MAC);
        out_en   = (state_q == OUT);
    end

    assign accept = in_valid && in_ready;
    assign wr_ok  = coef_ok && (coef_addr <= HALF_A);

    always_comb begin
        pre     = $signed({tap_lo[idx_q][DATA_W-1], tap_lo[idx_q]})
                + $signed({tap_hi[idx_q][DATA_W-1], tap_hi[idx_q]});
        prod    = pre * $signed(coef_q[idx_q]);
        acc_d   = acc_q + {{AW{prod[PROD_W-1]}}, prod};
        rnd_sum = acc_q + RND;
        r_full  = rnd_sum >>> SHIFT;
        clip    = 1'b0;
        r_sat   = r_full[OUT_W-1:0];
        if (r_full > OMAX) begin
            r_sat = OMAX[OUT_W-1:0];
            clip  = 1'b1;
        end else if (r_full < OMIN) begin
            r_sat = OMIN[OUT_W-1:0];
            clip  = 1'b1;
        end
    end

    always_ff @(posedge clock_s or negedge rst_n) begin
        if (!rst_n) begin
            line_q      <= '0;
            coef_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            coef_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                line_q <= {line_q[LEN-2:0], in_data};
                acc_q  <= '0;
                idx_q  <= '0;
            end else if (mac_en) begin
                acc_q <= acc_d;
                idx_q <= idx_q + 1'b1;
            end
            if (coef_we && wr_ok) coef_q[coef_addr] <= coef_wdata;
            coef_err_q  <= coef_we && !wr_ok;
            out_valid_q <= out_en;
            if (out_en) begin
                out_data_q <= r_sat;
                out_sat_q  <= clip;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_bc_fir_sym_mac.sv
// Bench for bc_fir_sym_mac: directed scenarios plus random traffic, all checked
// against a direct-form 19-tap reference model with its own cycle-level timing.
module tb_bc_fir_sym_mac;

    localparam int DATA_W = 13, COEF_W = 12, TAPS = 19, SPACING = 2, SHIFT = 11, OUT_W = 13;
    localparam int HALF = (TAPS - 1) / 2;
    localparam int AW   = $clog2(HALF + 1);
    localparam int LEN  = TAPS * SPACING;
    localparam longint OMAX = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OUT_W - 1));

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid, out_sat;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_err;

    always #5 clk = ~clk;

    bc_fir_sym_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SPACING(SPACING),
                     .SHIFT(SHIFT), .OUT_W(OUT_W)) u_dut (
        .clock_s(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_err(coef_err)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { longint due; longint val; bit sat; } exp_t;
    exp_t   q[$];
    longint hist[LEN];
    longint coefm[HALF+1];
    longint cyc = 0, last_acc = 0;
    bit     has_acc = 0, err_pend = 0;
    longint obs[$];
    bit     obs_sat[$];

    // cyc is the number of the rising edge that follows this falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            foreach (hist[j]) hist[j] = 0;
            foreach (coefm[j]) coefm[j] = 0;
            q.delete();
            has_acc  = 0;
            err_pend = 0;
        end else begin
            bit rdy, idle;
            longint y, r;
            exp_t e;
            cyc++;
            chk("coef_err", coef_err, err_pend);
            if (q.size() > 0 && q[0].due == cyc - 1) begin
                chk("out_valid", out_valid, 1);
                chk("out_data", longint'(out_data), q[0].val);
                chk("out_sat", out_sat, q[0].sat);
                obs.push_back(longint'(out_data));
                obs_sat.push_back(out_sat);
                void'(q.pop_front());
            end else begin
                chk("out_valid_idle", out_valid, 0);
            end
            rdy  = !(has_acc && cyc <= last_acc + 10);
            idle = !has_acc || cyc >= last_acc + 12;
            chk("in_ready", in_ready, rdy);
            err_pend = 0;
            if (coef_we) begin
                if (idle && int'(coef_addr) <= HALF) coefm[coef_addr] = longint'(coef_wdata);
                else err_pend = 1;
            end
            if (in_valid && rdy) begin
                for (int j = LEN - 1; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = longint'(in_data);
                y = 0;
                for (int k = 0; k < TAPS; k++)
                    y += coefm[(k <= HALF) ? k : TAPS - 1 - k] * hist[(k+1)*SPACING-1];
                r = (y + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
                e.sat = 0;
                if (r > OMAX) begin r = OMAX; e.sat = 1; end
                else if (r < OMIN) begin r = OMIN; e.sat = 1; end
                e.val = r;
                e.due = cyc + 11;
                q.push_back(e);
                last_acc = cyc;
                has_acc  = 1;
            end
        end
    end

    // ---------------- stimulus helpers (entered at posedge+1) ----------------
    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wcoef(input int a, input int d);
        coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = COEF_W'(d);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    // Holds the sample until the block takes it; returns just after the accept edge
    task automatic send(input int d);
        int n;
        n = 0;
        in_data = DATA_W'(d); in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
    endtask

    int tbl[19] = '{3, 0, -21, 0, 78, 0, -237, 0, 943, 1533, 943, 0, -237, 0, 78, 0, -21, 0, 3};
    int ic[10]  = '{3, 0, -21, 0, 78, 0, -237, 0, 943, 1533};

    initial begin
        longint prev;
        bit took;
        in_valid = 0; in_data = 0; coef_we = 0; coef_addr = 0; coef_wdata = 0;
        #3 rst_n = 1'b0;
        #9;
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_coef_err", coef_err, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", in_ready, 1);

        // reset in the middle of a computation
        wcoef(9, 1024); wcoef(0, 1000);
        for (int i = 0; i < 22; i++) send(1000 + i);
        send(77);
        in_valid = 1'b0;
        wcoef(3, 55);
        chk("mac_wr_err", coef_err, 1);
        chk("pre_rst_data_nz", longint'(out_data != 0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_data", longint'(out_data), 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_err", coef_err, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst2", in_ready, 1);
        wcoef(9, 1024); wcoef(0, 1000);
        obs.delete(); obs_sat.delete();
        send(500); drain();
        chk("post_rst_nout", obs.size(), 1);
        if (obs.size() > 0) chk("post_rst_zero_hist", obs[0], 0);

        // impulse response
        do_reset();
        for (int i = 0; i < 10; i++) wcoef(i, ic[i]);
        obs.delete(); obs_sat.delete();
        send(2048);
        for (int i = 0; i < 40; i++) send(0);
        drain();
        chk("imp_nout", obs.size(), 41);
        if (obs.size() == 41)
            for (int i = 0; i < 41; i++) begin
                chk("imp_val", obs[i], ((i % 2) == 1 && i <= 37) ? longint'(tbl[(i-1)/2]) : 0);
                chk("imp_sat", obs_sat[i], 0);
            end

        // round half up at the centre tap
        do_reset();
        wcoef(9, 1024);
        obs.delete(); obs_sat.delete();
        send(3);  for (int i = 0; i < 19; i++) send(0);
        send(-3); for (int i = 0; i < 19; i++) send(0);
        send(1);  for (int i = 0; i < 19; i++) send(0);
        drain();
        chk("rnd_nout", obs.size(), 60);
        if (obs.size() == 60) begin
            chk("rnd_pos_1p5", obs[19], 2);
            chk("rnd_neg_1p5", obs[39], -1);
            chk("rnd_pos_0p5", obs[59], 1);
        end

        // saturation
        do_reset();
        for (int i = 0; i <= HALF; i++) wcoef(i, 2047);
        obs.delete(); obs_sat.delete();
        for (int i = 0; i < 40; i++) send(4095);
        for (int i = 0; i < 40; i++) send(-4096);
        drain();
        chk("sat_nout", obs.size(), 80);
        if (obs.size() == 80) begin
            chk("sat_hi_val", obs[39], 4095);
            chk("sat_hi_flag", obs_sat[39], 1);
            chk("sat_lo_val", obs[79], -4096);
            chk("sat_lo_flag", obs_sat[79], 1);
        end

        // back-to-back handshake
        do_reset();
        wcoef(0, 512); wcoef(4, -300); wcoef(9, 700);
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            send(i * 37 - 200);
            if (i > 0) chk("acc_gap", cyc - prev, 11);
            prev = cyc;
        end
        drain();

        // coefficient access rules
        do_reset();
        wcoef(10, 5);
        chk("addr_err", coef_err, 1);
        wcoef(0, 600);
        chk("idle_wr_ok", coef_err, 0);
        send(2048);
        in_valid = 1'b0;
        wcoef(0, -5);
        chk("mac_wr_err2", coef_err, 1);
        drain();
        obs.delete(); obs_sat.delete();
        send(0); drain();
        if (obs.size() > 0) chk("coef_kept", obs[0], 600);
        else chk("coef_kept_nout", 0, 1);
        send(2048); drain();
        coef_we = 1'b1; coef_addr = 0; coef_wdata = 1024;
        obs.delete(); obs_sat.delete();
        send(7);
        coef_we = 1'b0;
        drain();
        if (obs.size() > 0) chk("acc_cycle_wr", obs[0], 1024);
        else chk("acc_cycle_wr_nout", 0, 1);

        // random traffic with random coefficient writes
        do_reset();
        for (int i = 0; i <= HALF; i++) wcoef(i, int'($urandom_range(0, 4095)) - 2048);
        took = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom % 3) != 0;
                in_data  = DATA_W'($urandom);
            end
            coef_we    = ($urandom % 6) == 0;
            coef_addr  = AW'($urandom % 12);
            coef_wdata = COEF_W'($urandom_range(0, 1023)) - COEF_W'(512);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bc_fir_sym_mac.md
Name: bc_fir_sym_mac

Overview:
- Parametrised successor of the fixed 19-tap binary FIR.
- Symmetric, odd-length FIR with configurable sample spacing in the delay line (SPACING).
- Coefficients are signed and runtime-programmable, the datapath is two's-complement, and one multiplier is time-multiplexed over the symmetric tap pairs.
- Adds valid/ready input handshake, round-half-up scaling and output saturation. Sits between the sample source and the SC comparison datapath as the binary reference filter.

Parameters:
- DATA_W, 13, signed input sample width.
- COEF_W, 12, signed coefficient width.
- TAPS, 19, filter length; must be odd and >= 3. HALF = (TAPS-1)/2.
- SPACING, 2, delay-line stride; tap k reads line[(k+1)*SPACING-1].
- SHIFT, 11, right shift applied to the accumulator before output.
- OUT_W, 13, signed output width.

Ports:
- clock_s  in  1  sampling/system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- out_data  out  OUT_W  signed filtered sample.
- out_valid  out  1  one-cycle pulse, out_data is new.
- out_sat  out  1  out_data was clipped; qualified by out_valid.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(HALF+1)  coefficient index 0..HALF; HALF = centre tap.
- coef_wdata  in  COEF_W  signed coefficient.
- coef_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Clock and reset: single clock, clock_s. rst_n is asynchronous and active-low.
- Reset values: on rst_n low, all of the following clear to 0 immediately:
  - delay line (TAPS*SPACING entries) and all coefficients;
  - accumulator and FSM (-> IDLE);
  - out_data, out_valid, out_sat, coef_err.
  - in_ready = 1 after reset deasserts.
- Coefficient mapping: coef[i] applies to taps i and TAPS-1-i; coef[HALF] applies to the centre tap only.
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready = 1. On in_valid && in_ready: shift the delay line (line[0] <= in_data, line[j] <= line[j-1]), clear the accumulator, set idx = 0, go to MAC.
  - MAC: in_ready = 0, one product per cycle.
    - idx < HALF: acc += coef[idx] * (tap[idx] + tap[TAPS-1-idx]), with the pre-add at DATA_W+1 bits.
    - idx == HALF: acc += coef[HALF] * tap[HALF], then go to OUT.
    - Takes HALF+1 cycles.
  - OUT: r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up).
    - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register it into out_data.
    - out_sat = 1 if clipped. out_valid = 1 for this one cycle. Return to IDLE.
- Accumulator: full precision, ACC_W = DATA_W + 1 + COEF_W + clog2(HALF+1); no internal wrap.
- Latency: accept edge -> out_valid asserted HALF+2 cycles later (11 at defaults). Maximum throughput is one sample per HALF+2 cycles.
- No output backpressure: out_data holds its value until the next OUT; out_valid is low otherwise.
- Coefficient writes:
  - Accepted in IDLE, including the same cycle as a sample accept; the new value is used by that computation.
  - In MAC or OUT the write is ignored and coef_err pulses for 1 cycle.
  - coef_addr > HALF is ignored and coef_err pulses.
- in_valid while in_ready = 0: sample not taken; the source must hold it.
- Reset mid-operation: any computation in progress is discarded and no out_valid is issued.

Test Plan (defaults):
1. Reset: assert rst_n low mid-MAC -> out_data = 0, out_valid = 0, coef_err = 0 immediately; after release in_ready = 1 and the first output reflects an all-zero history.
2. Impulse response:
   - Program coef[0..9] = 3, 0, -21, 0, 78, 0, -237, 0, 943, 1533.
   - Feed 2048, then 40 zeros -> outputs for accepts 1, 3, ..., 37 = 3, 0, -21, 0, 78, 0, -237, 0, 943, 1533, 943, 0, -237, 0, 78, 0, -21, 0, 3.
   - All even accepts -> 0. out_sat never set.
3. Rounding: only coef[9] = 1024 (others 0).
   - Input 3 -> centre output 2 (1.5 rounds up).
   - Input -3 -> -1.
   - Input 1 -> 1 (0.5 rounds up).
4. Saturation: all coefficients 2047.
   - DC 4095 -> steady-state out_data = 4095, out_sat = 1.
   - DC -4096 -> out_data = -4096, out_sat = 1.
5. Handshake: in_valid held high with incrementing data -> accepts exactly every 11 cycles, no sample skipped or duplicated, out_valid exactly 11 cycles after each accept.
6. Coefficient access:
   - Write during MAC -> coef_err pulse and the coefficient is unchanged (verify by a later impulse).
   - coef_addr = 10 in IDLE -> coef_err pulse.
   - Write in the accept cycle -> new value used.
